// File: rtl/auto_code_gen.sv
// auto_code_gen: inverse of the switch-to-LED class decoder.
// Scans the 4-bit switch codes in ascending order and emits, through a
// valid/ready handshake, every code whose LED class equals the target
// latched at start. Index never wraps: 4'hF is always the last code seen.
module auto_code_gen #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] target,
  input  logic       code_ready,
  output logic [3:0] sw_code,
  output logic       code_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] match_count,
  output logic       none_found
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [3:0] START_INDEX = SKIP_ZERO ? 4'h1 : 4'h0;

  // LED class produced by the forward decoder for a given switch code.
  function automatic logic [1:0] led_class(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h8, 4'h9: led_class = 2'b10;
      4'h3, 4'hA, 4'hC, 4'hD: led_class = 2'b01;
      default:                led_class = 2'b00;
    endcase
  endfunction

  state_t     r_state;
  logic [3:0] r_index;
  logic [1:0] r_target;
  logic [3:0] r_sw_code;
  logic       r_code_valid;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_match_count;
  logic       r_none_found;

  logic w_match;
  logic w_last;

  // Compare the current index against the latched class; class 2'b11 never matches.
  assign w_match = (led_class(r_index) == r_target);
  assign w_last  = (r_index == 4'hF);

  // Scan FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_index       <= 4'h0;
      r_target      <= 2'b00;
      r_sw_code     <= 4'h0;
      r_code_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_match_count <= 4'h0;
      r_none_found  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values; this default makes done a single-cycle
      // pulse unless the transition into DONE overrides it on this edge.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target      <= target;
            r_match_count <= 4'h0;
            r_none_found  <= 1'b0;
            r_index       <= START_INDEX;
            r_busy        <= 1'b1;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_match) begin
            r_sw_code    <= r_index;
            r_code_valid <= 1'b1;
            r_state      <= S_EMIT;
          end else if (w_last) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_none_found <= (r_match_count == 4'h0);
            r_state      <= S_DONE;
          end else begin
            r_index <= r_index + 4'h1;
          end
        end
        S_EMIT: begin
          if (abort) begin
            // Abort beats a simultaneous code_ready: the code is not counted.
            r_sw_code    <= 4'h0;
            r_code_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (code_ready) begin
            r_sw_code     <= 4'h0;
            r_code_valid  <= 1'b0;
            r_match_count <= r_match_count + 4'h1;
            if (w_last) begin
              // A code was just accepted, so this scan found at least one.
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_none_found <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_index <= r_index + 4'h1;
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sw_code     = r_sw_code;
  assign code_valid  = r_code_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign match_count = r_match_count;
  assign none_found  = r_none_found;

endmodule

// File: tb/tb_auto_code_gen.sv
// Self-checking bench for auto_code_gen: one instance with SKIP_ZERO=0 and one
// with SKIP_ZERO=1. Expected code sequences are pushed to per-instance queues
// when a scan starts and popped by negedge monitors on each accepted code.
module tb_auto_code_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start_sz;
  logic       abort;
  logic [1:0] target;
  logic       code_ready;

  logic [3:0] sw0, sw1;
  logic       cv0, cv1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [3:0] mc0, mc1;
  logic       nf0, nf1;

  int n_cmp;
  int n_fail;
  int dn0;
  int dn1;
  int q0[$];
  int q1[$];

  typedef struct {
    logic [1:0] tgt;
    bit         sz;
    int         exp_count;
    bit         exp_none;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[7];

  auto_code_gen #(.SKIP_ZERO(1'b0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .target     (target),
    .code_ready (code_ready),
    .sw_code    (sw0),
    .code_valid (cv0),
    .busy       (busy0),
    .done       (done0),
    .match_count(mc0),
    .none_found (nf0)
  );

  auto_code_gen #(.SKIP_ZERO(1'b1)) u_dut_sz (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_sz),
    .abort      (abort),
    .target     (target),
    .code_ready (code_ready),
    .sw_code    (sw1),
    .code_valid (cv1),
    .busy       (busy1),
    .done       (done1),
    .match_count(mc1),
    .none_found (nf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are stable from there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Codes of each LED class, in ascending order.
  task automatic push_expected(input logic [1:0] tgt, input bit sz);
    int codes[$];
    case (tgt)
      2'b10:   codes = '{1, 2, 8, 9};
      2'b01:   codes = '{3, 10, 12, 13};
      2'b00:   codes = '{0, 4, 5, 6, 7, 11, 14, 15};
      default: codes = '{};
    endcase
    foreach (codes[i]) begin
      if (!(sz && codes[i] == 0)) begin
        if (sz) q1.push_back(codes[i]);
        else    q0.push_back(codes[i]);
      end
    end
  endtask

  // Scoreboard: compare every accepted code and the idle value of sw_code.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cv0 && code_ready && !abort) begin
        if (q0.size() == 0) check("extra_code0", int'(sw0), 99);
        else                check("code0", int'(sw0), q0.pop_front());
      end
      if (!cv0) check("sw_idle0", int'(sw0), 0);
      if (done0) dn0++;
      if (cv1 && code_ready && !abort) begin
        if (q1.size() == 0) check("extra_code1", int'(sw1), 99);
        else                check("code1", int'(sw1), q1.pop_front());
      end
      if (!cv1) check("sw_idle1", int'(sw1), 0);
      if (done1) dn1++;
    end
  end

  // Full scan with code_ready held high; target is altered after the latch
  // and start is re-asserted during DONE, both of which must be ignored.
  task automatic run_scan(input logic [1:0] tgt, input bit sz, input int exp_count,
                          input bit exp_none, input int exp_cycles, input string tag);
    int n;
    int d_before;
    push_expected(tgt, sz);
    target     = tgt;
    code_ready = 1'b1;
    if (sz) start_sz = 1'b1;
    else    start    = 1'b1;
    cyc();
    start    = 1'b0;
    start_sz = 1'b0;
    target   = tgt ^ 2'b11;
    d_before = sz ? dn1 : dn0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(sz ? done1 : done0) && n < 200);
    check({tag, "_cycles_to_done"}, n, exp_cycles);
    check({tag, "_match_count"}, int'(sz ? mc1 : mc0), exp_count);
    check({tag, "_none_found"}, int'(sz ? nf1 : nf0), int'(exp_none));
    check({tag, "_codes_left"}, sz ? q1.size() : q0.size(), 0);
    if (sz) start_sz = 1'b1;
    else    start    = 1'b1;
    cyc();
    start    = 1'b0;
    start_sz = 1'b0;
    check({tag, "_idle_after_done"}, int'(sz ? busy1 : busy0), 0);
    check({tag, "_done_pulses"}, (sz ? dn1 : dn0) - d_before, 1);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int n;
    int d_before;

    n_cmp      = 0;
    n_fail     = 0;
    dn0        = 0;
    dn1        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_sz   = 1'b0;
    abort      = 1'b0;
    target     = 2'b00;
    code_ready = 1'b0;

    vecs[0] = '{tgt: 2'b10, sz: 1'b0, exp_count: 4, exp_none: 1'b0, exp_cycles: 20};
    vecs[1] = '{tgt: 2'b01, sz: 1'b0, exp_count: 4, exp_none: 1'b0, exp_cycles: 20};
    vecs[2] = '{tgt: 2'b00, sz: 1'b0, exp_count: 8, exp_none: 1'b0, exp_cycles: 24};
    vecs[3] = '{tgt: 2'b11, sz: 1'b0, exp_count: 0, exp_none: 1'b1, exp_cycles: 16};
    vecs[4] = '{tgt: 2'b00, sz: 1'b1, exp_count: 7, exp_none: 1'b0, exp_cycles: 22};
    vecs[5] = '{tgt: 2'b10, sz: 1'b1, exp_count: 4, exp_none: 1'b0, exp_cycles: 19};
    vecs[6] = '{tgt: 2'b11, sz: 1'b1, exp_count: 0, exp_none: 1'b1, exp_cycles: 15};

    // Reset state.
    #1;
    check("rst_sw_code", int'(sw0), 0);
    check("rst_code_valid", int'(cv0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_match_count", int'(mc0), 0);
    check("rst_none_found", int'(nf0), 0);
    check("rst_busy_sz", int'(busy1), 0);
    #22;
    rst_n = 1'b1;
    cyc();

    // Table-driven full scans.
    foreach (vecs[i]) begin
      run_scan(vecs[i].tgt, vecs[i].sz, vecs[i].exp_count, vecs[i].exp_none,
               vecs[i].exp_cycles, $sformatf("vec%0d", i));
    end

    // Back-pressure: code_ready low for 5 cycles while code 10 is offered.
    push_expected(2'b01, 1'b0);
    target     = 2'b01;
    code_ready = 1'b1;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!cv0 && n < 40) begin
      cyc();
      n++;
    end
    check("first_code_latency", n, 4);
    n = 0;
    while (!(cv0 && sw0 == 4'hA) && n < 40) begin
      cyc();
      n++;
    end
    code_ready = 1'b0;
    check("stall_valid", int'(cv0), 1);
    check("stall_code", int'(sw0), 10);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_valid_hold", int'(cv0), 1);
      check("stall_code_hold", int'(sw0), 10);
    end
    code_ready = 1'b1;
    n = 0;
    while (!done0 && n < 60) begin
      cyc();
      n++;
    end
    check("stall_done", int'(done0), 1);
    check("stall_match_count", int'(mc0), 4);
    check("stall_codes_left", q0.size(), 0);
    cyc();
    q0.delete();

    // Abort together with code_ready on code 12; repeated start mid-scan.
    q0.push_back(3);
    q0.push_back(10);
    target     = 2'b01;
    code_ready = 1'b1;
    start      = 1'b1;
    cyc();
    start    = 1'b0;
    d_before = dn0;
    n = 0;
    while (!(cv0 && sw0 == 4'hC) && n < 40) begin
      cyc();
      n++;
      start = (n == 3);
    end
    start = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_valid", int'(cv0), 0);
    check("abort_busy", int'(busy0), 0);
    check("abort_sw_code", int'(sw0), 0);
    check("abort_match_count", int'(mc0), 2);
    repeat (3) cyc();
    check("abort_no_done", dn0 - d_before, 0);
    check("abort_still_idle", int'(busy0), 0);
    check("abort_codes_left", q0.size(), 0);
    q0.delete();

    // Asynchronous reset while code 8 is being offered.
    push_expected(2'b10, 1'b0);
    target     = 2'b10;
    code_ready = 1'b1;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!(cv0 && sw0 == 4'h8) && n < 40) begin
      cyc();
      n++;
    end
    code_ready = 1'b0;
    check("pre_rst_code", int'(sw0), 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(cv0), 0);
    check("mid_rst_sw_code", int'(sw0), 0);
    check("mid_rst_busy", int'(busy0), 0);
    check("mid_rst_done", int'(done0), 0);
    check("mid_rst_match_count", int'(mc0), 0);
    check("mid_rst_none_found", int'(nf0), 0);
    check("mid_rst_codes_pending", q0.size(), 2);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    run_scan(2'b10, 1'b0, 4, 1'b0, 20, "rescan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/auto_code_gen.md
AUTO_CODE_GEN -- requirements
Module: auto_code_gen

Interface
REQ-001 Parameter: SKIP_ZERO, default 0, meaning 1 = code 4'h0 excluded from the scan (scan starts at 4'h1).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin scan request, sampled in IDLE only.
REQ-005 abort  input  1  synchronous cancel of an active scan.
REQ-006 target  input  2  LED class {led[1],led[0]} whose switch codes are to be generated.
REQ-007 code_ready  input  1  consumer accepts sw_code this cycle.
REQ-008 sw_code  output  4  generated switch code, sw[3:0], bit 0 = sw[0].
REQ-009 code_valid  output  1  sw_code holds a matching code.
REQ-010 busy  output  1  high in SCAN and EMIT.
REQ-011 done  output  1  one-cycle pulse at normal scan completion.
REQ-012 match_count  output  4  number of codes accepted in the current/last scan.
REQ-013 none_found  output  1  registered, set at done when match_count = 0.

Function
REQ-014 Class function, fixed: class 2'b10 for codes {1,2,8,9}; class 2'b01 for codes {3,10,12,13}; class 2'b00 for codes {0,4,5,6,7,11,14,15}; class 2'b11 has no codes.
REQ-015 The block shall be the inverse of the switch-to-LED decoder: it emits, in ascending order, every 4-bit code whose class equals the latched target.
REQ-016 FSM states IDLE, SCAN, EMIT, DONE; encoding at implementer's discretion.
REQ-017 IDLE: on start=1, latch target, clear match_count and none_found, load index (0, or 1 if SKIP_ZERO=1), go to SCAN next cycle.
REQ-018 SCAN: evaluate one index per cycle; match -> EMIT; no match and index=15 -> DONE; no match otherwise -> index+1, stay SCAN.
REQ-019 EMIT: sw_code=index, code_valid=1; hold both stable while code_ready=0.
REQ-020 EMIT with code_ready=1: match_count+1; index=15 -> DONE, else index+1 -> SCAN.
REQ-021 DONE: done=1 for exactly one cycle, none_found updated, then IDLE.
REQ-022 Latency: start to first code_valid = 2 + (first matching code - start index) cycles; full scan with no match = 16 SCAN cycles (15 if SKIP_ZERO).
REQ-023 Index shall not wrap: 15 is always the final index evaluated.
REQ-024 start while busy or in DONE shall be ignored; target changes after latch shall be ignored.
REQ-025 abort=1 in SCAN or EMIT -> IDLE next cycle, code_valid=0, no done pulse, match_count holds its partial value; abort wins over simultaneous code_ready.
REQ-026 abort in IDLE or DONE shall have no effect.
REQ-027 sw_code shall read 4'h0 whenever code_valid=0.
REQ-028 match_count maximum is 8; no overflow handling required.

Reset
REQ-029 rst_n=0 shall immediately force IDLE, sw_code=0, code_valid=0, busy=0, done=0, match_count=0, none_found=0, index=0, latched target=0.
REQ-030 Reset asserted mid-scan shall abandon the scan with no done pulse; first start after release begins a fresh scan.

Verification
REQ-031 target=2'b10, code_ready tied 1 -> codes 1,2,8,9 in order, done once, match_count=4, none_found=0.
REQ-032 target=2'b00, SKIP_ZERO=1, code_ready=1 -> codes 4,5,6,7,11,14,15, match_count=7.
REQ-033 target=2'b11 -> no code_valid, done after 16 SCAN cycles, match_count=0, none_found=1.
REQ-034 target=2'b01, code_ready low 5 cycles on code 10 -> sw_code=10 and code_valid held stable 5 cycles; sequence 3,10,12,13 intact.
REQ-035 target=2'b01, abort asserted with code_ready while sw_code=12 -> IDLE, no done, match_count=2; repeated start during scan ignored.
REQ-036 rst_n low during EMIT of code 8 (target 2'b10) -> all outputs 0 asynchronously; new start rescans from code 1.
